// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: shares one register-file port between NUM_REQ requesters.
// Requesters are served round-robin. Each grant gives one strobe cycle
// (ACCESS) and then one acknowledge cycle (RESP).
// Optional feature macro: REG_ARB_LOCK_EN adds a lock for atomic read-modify-write.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/write     per-requester request and direction (1 = write)
//   req_addr/wdata      flattened per-requester address and data; slot i is [i*W +: W]
//   req_lock            per-requester lock request (only with REG_ARB_LOCK_EN)
//   req_ready           one-hot completion pulse
//   req_rdata           read data, valid while req_ready is high
//   reg_addr/wdata      register-file address and write data
//   reg_write_en        register-file write strobe
//   reg_read_en         register-file read strobe
//   reg_rdata           register-file read data
//   grant_id            index of the current or last winner
//   busy                high during ACCESS and RESP
//   lock_active         high while a lock is held
module reg_access_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [ADDR_WIDTH-1:0]         reg_addr,
    output logic [DATA_WIDTH-1:0]         reg_wdata,
    output logic                          reg_write_en,
    output logic                          reg_read_en,
    input  logic [DATA_WIDTH-1:0]         reg_rdata,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          lock_active
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         last_grant_q, last_grant_d, grant_id_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   reg_addr_d;
    logic [DATA_WIDTH-1:0]   reg_wdata_d;
    logic                    reg_write_en_d, reg_read_en_d, busy_d;
    logic [NUM_REQ-1:0]      req_ready_d;
    logic [DATA_WIDTH-1:0]   req_rdata_d;

    logic                    found;
    logic [ID_W-1:0]         win;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic                    win_write;

`ifdef REG_ARB_LOCK_EN
    logic                    lock_active_d, lock_req_q, lock_req_d, win_lock;
    logic [ID_W-1:0]         lock_owner_q, lock_owner_d;
`else
    logic                    lock_unused;
    assign lock_unused = ^req_lock;
    assign lock_active = 1'b0;
`endif

    // Winner search: first set req_valid bit starting after last_grant
    always_comb begin
        found = 1'b0;
        win   = last_grant_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[ID_W'((32'(last_grant_q) + k) % NUM_REQ)]) begin
                found = 1'b1;
                win   = ID_W'((32'(last_grant_q) + k) % NUM_REQ);
            end
        end
`ifdef REG_ARB_LOCK_EN
        // A held lock excludes everyone except the owner; the pointer is left alone while others wait
        if (lock_active) begin
            found = req_valid[lock_owner_q];
            win   = lock_owner_q;
        end
`endif
    end

    // Select the winner's request fields
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_write = 1'b0;
`ifdef REG_ARB_LOCK_EN
        win_lock  = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                win_write = req_write[i];
`ifdef REG_ARB_LOCK_EN
                win_lock  = req_lock[i];
`endif
            end
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_id_d     = grant_id;
        wr_d           = wr_q;
        reg_addr_d     = reg_addr;
        reg_wdata_d    = reg_wdata;
        reg_write_en_d = 1'b0;
        reg_read_en_d  = 1'b0;
        req_ready_d    = '0;
        req_rdata_d    = '0;
        busy_d         = 1'b0;
`ifdef REG_ARB_LOCK_EN
        lock_active_d  = lock_active;
        lock_owner_d   = lock_owner_q;
        lock_req_d     = lock_req_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d        = ACCESS;
                    last_grant_d   = win;
                    grant_id_d     = win;
                    wr_d           = win_write;
                    reg_addr_d     = win_addr;
                    reg_wdata_d    = win_wdata;
                    reg_write_en_d = win_write;
                    reg_read_en_d  = !win_write;
                    busy_d         = 1'b1;
`ifdef REG_ARB_LOCK_EN
                    lock_req_d     = win_lock;
`endif
                end
            end
            ACCESS: begin
                state_d     = RESP;
                busy_d      = 1'b1;
                req_ready_d = NUM_REQ'(1) << grant_id;
                req_rdata_d = wr_q ? '0 : reg_rdata;
`ifdef REG_ARB_LOCK_EN
                // Lock state changes become visible in the RESP cycle
                if (lock_req_q) begin
                    lock_active_d = 1'b1;
                    lock_owner_d  = grant_id;
                end else if (grant_id == lock_owner_q) begin
                    lock_active_d = 1'b0;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_id     <= '0;
            wr_q         <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            reg_write_en <= 1'b0;
            reg_read_en  <= 1'b0;
            req_ready    <= '0;
            req_rdata    <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id     <= grant_id_d;
            wr_q         <= wr_d;
            reg_addr     <= reg_addr_d;
            reg_wdata    <= reg_wdata_d;
            reg_write_en <= reg_write_en_d;
            reg_read_en  <= reg_read_en_d;
            req_ready    <= req_ready_d;
            req_rdata    <= req_rdata_d;
            busy         <= busy_d;
        end
    end

`ifdef REG_ARB_LOCK_EN
    // Lock registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active  <= 1'b0;
            lock_owner_q <= '0;
            lock_req_q   <= 1'b0;
        end else begin
            lock_active  <= lock_active_d;
            lock_owner_q <= lock_owner_d;
            lock_req_q   <= lock_req_d;
        end
    end
`endif

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter (NUM_REQ=2). A scoreboard holds the expected
// strobes and responses; a negedge monitor pops and compares them.
module tb_reg_access_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid, req_write, req_lock, req_ready;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [DW-1:0]      req_rdata, reg_wdata, reg_rdata;
    logic [AW-1:0]      reg_addr;
    logic               reg_write_en, reg_read_en, busy, lock_active;
    logic [0:0]         grant_id;

    always #5 clk = ~clk;

    reg_access_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_lock(req_lock), .req_ready(req_ready),
        .req_rdata(req_rdata), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_write_en(reg_write_en), .reg_read_en(reg_read_en),
        .reg_rdata(reg_rdata), .grant_id(grant_id), .busy(busy),
        .lock_active(lock_active)
    );

    // Register-file model with a few preloaded locations
    logic [DW-1:0] mem [0:255];
    logic          mem_clear;
    assign reg_rdata = mem[reg_addr];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h0000A5A5;
            mem[8] <= 32'h12345678;
        end else if (reg_write_en) begin
            mem[reg_addr] <= reg_wdata;
        end
    end

    typedef struct {
        int          id;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } strb_t;
    typedef struct {
        logic [1:0]  ready;
        logic [31:0] rdata;
    } resp_t;

    strb_t sq[$];
    resp_t rq[$];
    strb_t se;
    resp_t re;
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_access(input int id, input logic wr, input logic [7:0] a,
                                 input logic [31:0] d, input logic [31:0] rd);
        strb_t s;
        resp_t r;
        s.id = id; s.wr = wr; s.addr = a; s.wdata = d;
        r.ready = 2'b01 << id;
        r.rdata = wr ? 32'h0 : rd;
        sq.push_back(s);
        rq.push_back(r);
    endtask

    // Monitor: compare every strobe and every ready pulse against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_write_en || reg_read_en) begin
                check("strobe_exclusive", 64'(reg_write_en & reg_read_en), 64'(0));
                if (sq.size() == 0) begin
                    check("unexpected_strobe", 64'(1), 64'(0));
                end else begin
                    se = sq.pop_front();
                    check("strobe_write", 64'(reg_write_en), 64'(se.wr));
                    check("strobe_addr", 64'(reg_addr), 64'(se.addr));
                    check("strobe_grant", 64'(grant_id), 64'(se.id));
                    if (se.wr) check("strobe_wdata", 64'(reg_wdata), 64'(se.wdata));
                end
            end
            if (req_ready != 2'b00) begin
                if (rq.size() == 0) begin
                    check("unexpected_ready", 64'(req_ready), 64'(0));
                end else begin
                    re = rq.pop_front();
                    check("resp_ready", 64'(req_ready), 64'(re.ready));
                    check("resp_rdata", 64'(req_rdata), 64'(re.rdata));
                end
            end
        end
    end

    task automatic set_req(input int id, input logic wr, input logic [7:0] a,
                           input logic [31:0] d, input logic lk);
        req_write[id] = wr;
        req_addr[id*AW +: AW] = a;
        req_wdata[id*DW +: DW] = d;
        req_lock[id] = lk;
        req_valid[id] = 1'b1;
    endtask

    // One access by requester id, with cycle-exact latency and busy checks
    task automatic do_access(input int id, input logic wr, input logic [7:0] a,
                             input logic [31:0] d, input logic [31:0] rd, input bit early);
        logic [1:0] oh;
        oh = 2'b01 << id;
        expect_access(id, wr, a, d, rd);
        set_req(id, wr, a, d, 1'b0);
        @(posedge clk); #1;
        // ACCESS: scramble request fields, they must have been latched already
        req_valid = req_valid & oh;
        req_addr[id*AW +: AW] = ~a;
        req_wdata[id*DW +: DW] = ~d;
        req_write[id] = ~wr;
        if (early) req_valid[id] = 1'b0;
        @(negedge clk);
        check("acc_strobes", 64'({reg_write_en, reg_read_en}), wr ? 64'(2) : 64'(1));
        check("acc_busy", 64'(busy), 64'(1));
        check("acc_no_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        @(negedge clk);
        check("resp_ready_pulse", 64'(req_ready), 64'(oh));
        check("resp_busy", 64'(busy), 64'(1));
        check("resp_no_strobe", 64'({reg_write_en, reg_read_en}), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_no_ready", 64'(req_ready), 64'(0));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = '0;
        req_lock = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_clear = 1'b1;
        req_valid = '0; req_write = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 mem_clear = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_strobes", 64'({reg_write_en, reg_read_en}), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        check("rst_lock_active", 64'(lock_active), 64'(0));
        check("rst_rdata", 64'(req_rdata), 64'(0));
        check("rst_reg_addr", 64'(reg_addr), 64'(0));
        check("rst_reg_wdata", 64'(reg_wdata), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single write, single read, read-back of the write
        do_access(0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        check("hold_reg_addr", 64'(reg_addr), 64'(8'h10));
        do_access(1, 1'b0, 8'h04, 32'h0, 32'h0000A5A5, 1'b0);
        do_access(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Contention: both valid 12 cycles after reset -> 0,1,0,1
        apply_reset();
        expect_access(0, 1'b1, 8'h20, 32'h11111111, 32'h0);
        expect_access(1, 1'b0, 8'h04, 32'h0, 32'h0000A5A5);
        expect_access(0, 1'b1, 8'h20, 32'h11111111, 32'h0);
        expect_access(1, 1'b0, 8'h04, 32'h0, 32'h0000A5A5);
        set_req(0, 1'b1, 8'h20, 32'h11111111, 1'b0);
        set_req(1, 1'b0, 8'h04, 32'h0, 1'b0);
        repeat (12) @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1 check("contention_drained", 64'(sq.size() + rq.size()), 64'(0));

        // Early withdrawal: access completes, no further access follows
        do_access(0, 1'b1, 8'h30, 32'hCAFEF00D, 32'h0, 1'b1);
        repeat (5) @(posedge clk);
        #1 check("withdraw_written", 64'(mem[8'h30]), 64'(32'hCAFEF00D));

        // Reset during ACCESS
        set_req(1, 1'b1, 8'h40, 32'h00000055, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("midrst_write_en", 64'(reg_write_en), 64'(0));
        check("midrst_ready", 64'(req_ready), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_no_write", 64'(mem[8'h40]), 64'(0));
        set_req(1, 1'b0, 8'h04, 32'h0, 1'b0);
        do_access(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        repeat (3) @(posedge clk);

`ifdef REG_ARB_LOCK_EN
        // Locked read-modify-write by req 0 while req 1 waits
        apply_reset();
        expect_access(0, 1'b0, 8'h08, 32'h0, 32'h12345678);
        expect_access(0, 1'b1, 8'h08, 32'h12345679, 32'h0);
        expect_access(1, 1'b1, 8'h50, 32'h00000077, 32'h0);
        set_req(0, 1'b0, 8'h08, 32'h0, 1'b1);
        set_req(1, 1'b1, 8'h50, 32'h00000077, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("lock_not_yet", 64'(lock_active), 64'(0));
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'h08, 32'h12345679, 1'b0);
        @(negedge clk);
        check("lock_set_at_resp", 64'(lock_active), 64'(1));
        @(posedge clk);
        @(negedge clk);
        check("lock_held_idle", 64'(lock_active), 64'(1));
        @(posedge clk);
        @(negedge clk);
        check("lock_owner_regrant", 64'(grant_id), 64'(0));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("lock_released", 64'(lock_active), 64'(0));
        repeat (3) @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("lock_rmw_value", 64'(mem[8'h08]), 64'(32'h12345679));
`else
        // Without the lock feature req_lock is ignored: pure round-robin
        apply_reset();
        expect_access(0, 1'b0, 8'h08, 32'h0, 32'h12345678);
        expect_access(1, 1'b1, 8'h50, 32'h00000077, 32'h0);
        set_req(0, 1'b0, 8'h08, 32'h0, 1'b1);
        set_req(1, 1'b1, 8'h50, 32'h00000077, 1'b0);
        repeat (2) @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("nolock_inactive", 64'(lock_active), 64'(0));
        repeat (3) @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
`endif
        #1 check("scoreboard_empty", 64'(sq.size() + rq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
